// File: rtl/route_reserve_arbiter.sv
// rtl/route_reserve_arbiter.sv - per-output round-robin route reservation with owner hold until relieve
module route_reserve_arbiter #(
  parameter int PORTS         = 5,
  parameter int REQUEST_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORTS-1:0]               req_valid,
  input  logic [PORTS*REQUEST_WIDTH-1:0] req_port,
  input  logic [PORTS-1:0]               route_relieve,
  output logic [PORTS-1:0]               reserve_status,
  output logic [PORTS-1:0]               out_busy,
  output logic [PORTS*REQUEST_WIDTH-1:0] out_sel
);

  logic [PORTS-1:0]         reserved;
  logic [REQUEST_WIDTH-1:0] owner [PORTS];
  logic [REQUEST_WIDTH-1:0] rr    [PORTS];

  logic [REQUEST_WIDTH-1:0] reqIdx   [PORTS];
  logic [PORTS-1:0]         holding;
  logic [PORTS-1:0]         grantHit;
  logic [REQUEST_WIDTH-1:0] grantIdx [PORTS];
  int                       k;

  always_comb begin
    holding = '0;
    grantHit = '0;
    k = 0;
    for (int i = 0; i < PORTS; i++) begin
      reqIdx[i]   = req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH];
      grantIdx[i] = '0;
    end
    for (int j = 0; j < PORTS; j++)
      for (int i = 0; i < PORTS; i++)
        if (reserved[j] && owner[j] == REQUEST_WIDTH'(i))
          holding[i] = 1'b1;
    // Requests for indices >= PORTS never match any j, so they are silently dropped.
    for (int j = 0; j < PORTS; j++) begin
      if (!reserved[j]) begin
        for (int off = 0; off < PORTS; off++) begin
          k = (int'(rr[j]) + off) % PORTS;
          if (!grantHit[j] && req_valid[k] && !holding[k] && reqIdx[k] == REQUEST_WIDTH'(j)) begin
            grantHit[j] = 1'b1;
            grantIdx[j] = REQUEST_WIDTH'(k);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reserved       <= '0;
      reserve_status <= '0;
      for (int j = 0; j < PORTS; j++) begin
        owner[j] <= '0;
        rr[j]    <= '0;
      end
    end else begin
      reserve_status <= '0;
      for (int j = 0; j < PORTS; j++) begin
        if (grantHit[j]) begin
          reserved[j]                 <= 1'b1;
          owner[j]                    <= grantIdx[j];
          rr[j]                       <= (grantIdx[j] == REQUEST_WIDTH'(PORTS-1)) ? '0
                                         : grantIdx[j] + REQUEST_WIDTH'(1);
          reserve_status[grantIdx[j]] <= 1'b1;
        end else if (reserved[j] && route_relieve[owner[j]]) begin
          reserved[j] <= 1'b0;
          owner[j]    <= '0;
        end
      end
    end
  end

  assign out_busy = reserved;

  for (genvar j = 0; j < PORTS; j++) begin : g_sel
    assign out_sel[j*REQUEST_WIDTH +: REQUEST_WIDTH] = owner[j];
  end

endmodule

// File: tb/tb_route_reserve_arbiter.sv
// tb/tb_route_reserve_arbiter.sv - directed checks of route_reserve_arbiter grant, hold, relieve and reset
module tb_route_reserve_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid;
  logic [14:0] req_port;
  logic [4:0]  route_relieve;
  logic [4:0]  reserve_status;
  logic [4:0]  out_busy;
  logic [14:0] out_sel;

  int total = 0;
  int passed = 0;

  route_reserve_arbiter #(.PORTS(5), .REQUEST_WIDTH(3)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_port(req_port),
    .route_relieve(route_relieve),
    .reserve_status(reserve_status),
    .out_busy(out_busy),
    .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input int p0, input int p1, input int p2, input int p3, input int p4);
    return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check3(input string tag, input logic [4:0] st, input logic [4:0] busy, input logic [14:0] sel);
    check({tag, ".status"}, 15'(reserve_status), 15'(st));
    check({tag, ".busy"}, 15'(out_busy), 15'(busy));
    check({tag, ".sel"}, out_sel, sel);
  endtask

  initial begin
    rst = 1'b1;
    route_relieve = '0;
    req_valid = 5'($urandom);
    req_port = 15'($urandom);
    tick;
    check3("reset1", 5'b00000, 5'b00000, 15'h0);
    req_valid = 5'($urandom);
    req_port = 15'($urandom);
    tick;
    check3("reset2", 5'b00000, 5'b00000, 15'h0);

    rst = 1'b0;
    req_valid = 5'b00001;
    req_port = pk(2, 0, 0, 0, 0);
    tick;
    check3("post_reset_grant", 5'b00001, 5'b00100, 15'h0);
    req_valid = '0;
    route_relieve = 5'b00001;
    tick;
    check3("post_reset_relieve", 5'b00000, 5'b00000, 15'h0);
    route_relieve = '0;

    // single grant, requester holds valid one more cycle
    req_valid = 5'b00001;
    req_port = pk(3, 0, 0, 0, 0);
    tick;
    check3("single_grant", 5'b00001, 5'b01000, 15'h0);
    tick;
    check3("single_no_regrant", 5'b00000, 5'b01000, 15'h0);
    req_valid = '0;
    route_relieve = 5'b00001;
    tick;
    check3("single_relieve", 5'b00000, 5'b00000, 15'h0);
    route_relieve = '0;

    // contention on output 4: rr[4]=0 so input 1 beats input 2
    req_valid = 5'b00110;
    req_port = pk(0, 4, 4, 0, 0);
    tick;
    check3("contend_win1", 5'b00010, 5'b10000, pk(0, 0, 0, 0, 1));
    req_valid = 5'b00100;
    tick;
    check3("contend_wait2", 5'b00000, 5'b10000, pk(0, 0, 0, 0, 1));
    route_relieve = 5'b00010;
    tick;
    check3("contend_relieve1", 5'b00000, 5'b00000, 15'h0);
    route_relieve = '0;
    tick;
    check3("contend_win2", 5'b00100, 5'b10000, pk(0, 0, 0, 0, 2));

    // rr[4] is now 3: input 4 must beat input 2
    req_valid = '0;
    route_relieve = 5'b00100;
    tick;
    check3("rr_relieve2", 5'b00000, 5'b00000, 15'h0);
    route_relieve = '0;
    req_valid = 5'b10100;
    req_port = pk(0, 0, 4, 0, 4);
    tick;
    check3("rr_win4", 5'b10000, 5'b10000, pk(0, 0, 0, 0, 4));
    req_valid = 5'b00100;
    route_relieve = 5'b10000;
    tick;
    check3("rr_relieve4", 5'b00000, 5'b00000, 15'h0);
    route_relieve = '0;
    tick;
    check3("rr_wrap_win2", 5'b00100, 5'b10000, pk(0, 0, 0, 0, 2));
    req_valid = '0;
    route_relieve = 5'b00100;
    tick;
    check3("rr_final_relieve", 5'b00000, 5'b00000, 15'h0);
    route_relieve = '0;

    // parallel grants 0->1, 2->3, 4->0
    req_valid = 5'b10101;
    req_port = pk(1, 0, 3, 0, 0);
    tick;
    check3("parallel", 5'b10101, 5'b01011, pk(4, 0, 0, 2, 0));
    req_valid = '0;
    tick;
    check3("parallel_hold", 5'b00000, 5'b01011, pk(4, 0, 0, 2, 0));

    // reset while three outputs are reserved
    rst = 1'b1;
    tick;
    check3("mid_reset", 5'b00000, 5'b00000, 15'h0);
    rst = 1'b0;

    // relieve and re-request from the same input in one cycle
    req_valid = 5'b01000;
    req_port = pk(0, 0, 0, 0, 0);
    tick;
    check3("rereq_grant", 5'b01000, 5'b00001, pk(3, 0, 0, 0, 0));
    route_relieve = 5'b01000;
    tick;
    check3("rereq_t1", 5'b00000, 5'b00000, 15'h0);
    route_relieve = '0;
    tick;
    check3("rereq_t2", 5'b01000, 5'b00001, pk(3, 0, 0, 0, 0));
    req_valid = '0;
    route_relieve = 5'b01000;
    tick;
    check3("rereq_release", 5'b00000, 5'b00000, 15'h0);
    route_relieve = '0;

    // out-of-range port index never granted, in-range neighbour unaffected
    req_valid = 5'b00010;
    req_port = pk(0, 6, 0, 0, 0);
    tick;
    check3("oor_c1", 5'b00000, 5'b00000, 15'h0);
    tick;
    check3("oor_c2", 5'b00000, 5'b00000, 15'h0);
    req_valid = 5'b00011;
    req_port = pk(1, 5, 0, 0, 0);
    tick;
    check3("oor_mixed", 5'b00001, 5'b00010, 15'h0);
    tick;
    check3("oor_mixed_hold", 5'b00000, 5'b00010, 15'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
